// File: rtl/prv32_mdu_if.sv
// prv32_mdu_if: operand/result bundle between the execute stage and the multiply/divide unit
interface prv32_mdu_if;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] r;
  modport master (output start, funct3, a, b, input busy, done, r);
  modport slave  (input start, funct3, a, b, output busy, done, r);
endinterface

// File: rtl/prv32_mdu.sv
// prv32_mdu: iterative RV32M multiply/divide, one bit per cycle
module prv32_mdu (
  input logic      clk,
  input logic      rst,
  prv32_mdu_if.slave io
);
  typedef enum logic [1:0] {IDLE, CALC, FIN, DONE} state_t;
  state_t      state;
  logic [2:0]  f3;
  logic [31:0] m;
  logic [63:0] acc;
  logic        neg;
  logic [5:0]  cnt;
  logic [31:0] r;
  logic        sa, sb, dz, ovf;
  logic [31:0] ma_in, mb_in, q, rm;
  logic [32:0] sum, trial;
  logic [63:0] p;
  // operand signedness, magnitudes, fast-path detection and per-iteration datapath
  always_comb begin
    sa = io.a[31] & (io.funct3[2] ? ~io.funct3[0] : io.funct3[1:0] != 2'b11);
    sb = io.b[31] & (io.funct3[2] ? ~io.funct3[0] : ~io.funct3[1]);
    ma_in = sa ? -io.a : io.a;
    mb_in = sb ? -io.b : io.b;
    dz = io.funct3[2] & (io.b == 32'h0);
    ovf = io.funct3[2] & ~io.funct3[0] & (io.a == 32'h8000_0000) & (io.b == 32'hffff_ffff);
    sum = {1'b0, acc[63:32]} + {1'b0, m};
    trial = acc[63:31] - {1'b0, m};
    p = neg ? -acc : acc;
    q = neg ? -acc[31:0] : acc[31:0];
    rm = neg ? -acc[63:32] : acc[63:32];
  end
  // control FSM: acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      f3 <= 3'b0;
      m <= 32'h0;
      acc <= 64'h0;
      neg <= 1'b0;
      cnt <= 6'h0;
      r <= 32'h0;
    end else begin
      case (state)
        IDLE: if (io.start) begin
          f3 <= io.funct3;
          neg <= sa ^ (sb & ~(io.funct3[2] & io.funct3[1]));
          m <= io.funct3[2] ? mb_in : ma_in;
          acc <= {32'h0, io.funct3[2] ? ma_in : mb_in};
          cnt <= 6'h0;
          if (dz | ovf) begin
            r <= dz ? (io.funct3[1] ? io.a : 32'hffff_ffff) : (io.funct3[1] ? 32'h0 : 32'h8000_0000);
            state <= DONE;
          end else
            state <= CALC;
        end
        CALC: begin
          acc <= f3[2] ? (trial[32] ? {acc[62:0], 1'b0} : {trial[31:0], acc[30:0], 1'b1})
                       : (acc[0] ? {sum, acc[31:1]} : {1'b0, acc[63:1]});
          cnt <= cnt + 6'd1;
          state <= cnt == 6'd31 ? FIN : CALC;
        end
        FIN: begin
          r <= f3[2] ? (f3[1] ? rm : q) : (f3[1:0] == 2'b00 ? p[31:0] : p[63:32]);
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign io.busy = state == CALC || state == FIN;
  assign io.done = state == DONE;
  assign io.r = r;
endmodule

// File: doc/prv32_mdu.md
# prv32_mdu

Iterative multiply/divide unit for the RV32M extension. It sits in the execute stage beside the ALU and takes the same decoded operands from the ID/EX register. Its result feeds the same EX/MEM result mux as the ALU result. Each operation takes multiple cycles, so the unit raises `busy` and the pipeline stalls until `done` pulses.

## Interface
- No parameters; XLEN fixed at 32.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a new operation; sampled only in IDLE.
- `funct3`  in  3  operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `a`  in  32  rs1 operand (dividend / multiplicand).
- `b`  in  32  rs2 operand (divisor / multiplier).
- `busy`  out  1  high while an accepted operation is in progress; drives the hazard-unit stall.
- `done`  out  1  one-cycle pulse; `r` is valid in that cycle.
- `r`  out  32  result register; holds its value until the next accepted `start`.

## Operation
- States: IDLE, CALC, FIN, DONE.
- Accepting a request (IDLE with `start`=1 at a rising edge):
  - latch `funct3`;
  - latch operand magnitudes (absolute value when the operand is treated as signed) and the result sign;
  - clear the 6-bit iteration counter;
  - go to CALC.
- Signedness: MUL/MULH/DIV/REM treat both operands as signed. MULHSU treats `a` as signed and `b` as unsigned. MULHU/DIVU/REMU are unsigned.
- Multiply (CALC, one bit per cycle):
  - shift-add on a 64-bit accumulator, 32 iterations, on unsigned magnitudes;
  - in FIN, negate the 64-bit product if the result sign is negative;
  - MUL returns the low 32 bits; the MULH variants return the high 32 bits.
- Divide (CALC, one bit per cycle):
  - restoring division, 32 iterations;
  - each iteration: form a 33-bit trial subtract of the divisor from {remainder, next dividend bit}; if it is non-negative, keep it and shift in quotient bit 1, otherwise shift in 0;
  - in FIN, the quotient takes sign a[31]^b[31] for DIV;
  - the remainder takes the sign of `a` for REM.
- Fast paths, decided in IDLE; `r` is written at the accepting edge and the state goes straight to DONE:
  - divide by zero (b=0): DIV/DIVU give 0xFFFFFFFF; REM/REMU give `a`;
  - signed overflow (DIV/REM with a=0x80000000, b=0xFFFFFFFF): DIV gives 0x80000000, REM gives 0.
- CALC to FIN after the 32nd iteration (counter = 31). FIN writes `r` and goes to DONE. DONE goes to IDLE unconditionally.
- `start` is ignored in CALC, FIN and DONE: no queueing and no abort.
- Operands are latched at acceptance, so changes on `a`, `b` or `funct3` after the accepting edge have no effect.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `r`=0, counter=0, internal accumulators 0.
- `busy`=1 in CALC and FIN only. It is combinational from the state register, so it is high in the cycle right after the accepting edge.
- `done`=1 exactly in the DONE state, for one cycle.
- Normal latency: accepting edge E0, iterations on edges E1..E32, FIN at E33, `done` high in the cycle after E33. That is 34 cycles from `start` to `done`, and the next `start` can be accepted at the edge that leaves DONE plus one (IDLE).
- Fast-path latency: `done` high in the cycle after E0, and `busy` never asserts.
- Reset mid-operation: the operation is abandoned and all outputs return to their reset values immediately. No `done` is produced for the abandoned operation.
- `start` held high continuously: a new operation is accepted on every IDLE cycle, so back-to-back operations are spaced 35 cycles apart.

## Test plan
- MUL a=7, b=-3 (0xFFFFFFFD) -> `done` 34 cycles after `start`; `r`=0xFFFFFFEB; `busy` high for exactly 33 cycles.
- MULH a=0x80000000, b=0x80000000 -> r=0x40000000. MULHU a=b=0xFFFFFFFF -> r=0xFFFFFFFE. MULHSU a=-1, b=0xFFFFFFFF -> r=0xFFFFFFFF.
- DIV a=-7, b=2 -> r=0xFFFFFFFD (-3). REM same operands -> r=0xFFFFFFFF (-1). DIVU a=100, b=7 -> r=14. REMU same operands -> r=2.
- DIVU a=5, b=0 -> r=0xFFFFFFFF, `done` in the cycle after `start`, `busy` never high. DIV 0x80000000 / 0xFFFFFFFF -> r=0x80000000. REM with the same operands -> r=0.
- Assert `rst` at cycle 10 of a DIV -> `busy`, `done` and `r` go to 0 immediately. A new MUL 3x4 after reset is released gives r=12 with full latency.
- Hold `start`=1 and change `a` mid-CALC -> the result reflects the latched operands. The second request is accepted only once IDLE is reached and yields its own `done` pulse.
